// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the instruction sequencer: opcodes, phase-enable
// codes, FSM state encoding and the decoded-instruction flag bundle.
package cpu_ctrl_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] EN_FETCH  = 4'b1000;
   localparam logic [3:0] EN_DECODE = 4'b0001;
   localparam logic [3:0] EN_EXEC   = 4'b0010;
   localparam logic [3:0] EN_MEM    = 4'b0100;
   localparam logic [3:0] EN_IDLE   = 4'b0000;

   localparam int unsigned PC_INC = 4;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } seq_state_t;

   typedef struct packed {
      logic legal;
      logic is_load;
      logic is_branch;
      logic writes_rd;
   } dec_flags_t;

   function automatic logic [3:0] phase_en(input seq_state_t s);
      logic [3:0] code;
      case (s)
         ST_FETCH:  code = EN_FETCH;
         ST_DECODE: code = EN_DECODE;
         ST_EXEC:   code = EN_EXEC;
         ST_MEM:    code = EN_MEM;
         default:   code = EN_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: flags whether an opcode is supported, is a
// load, is a branch, and whether it writes the destination register.
module opcode_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       legal,
   output logic       is_load,
   output logic       is_branch,
   output logic       writes_rd
);

   always_comb begin
      legal     = 1'b0;
      is_load   = 1'b0;
      is_branch = 1'b0;
      writes_rd = 1'b0;
      case (opcode)
         OPC_LUI: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
         end
         OPC_BRANCH: begin
            legal     = 1'b1;
            is_branch = 1'b1;
         end
         OPC_LOAD: begin
            legal     = 1'b1;
            is_load   = 1'b1;
            writes_rd = 1'b1;
         end
         OPC_OP: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the basic datapath.
// Owns the program counter and the retired-instruction counter.
module instr_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            instr_req,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   output logic [6:0]      opcode,
   output logic [3:0]      en,
   output logic            mem_req,
   input  logic            mem_ack,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] pc_offset,
   output logic [PC_W-1:0] pc,
   output logic            wb_en,
   output logic            illegal,
   output logic [31:0]     retired
);

   // Handshakes: instr_req (mem_req) stays high for the whole FETCH (MEM) phase and
   // the phase ends at the first rising edge where instr_valid (mem_ack) is high.
   // A response outside its phase is ignored; reset drops any outstanding request.

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

   seq_state_t      state;
   seq_state_t      state_n;
   dec_flags_t      flags;
   dec_flags_t      flags_n;
   dec_flags_t      dec_in;
   logic [PC_W-1:0] pc_n;
   logic            dec_legal;
   logic            dec_load;
   logic            dec_branch;
   logic            dec_wr;
   logic            unused_instr_hi;

   assign unused_instr_hi = ^instr[31:7];

   // Decode the word as it arrives so the DECODE-cycle outputs can be registered.
   opcode_decoder u_dec (
      .opcode    (instr[6:0]),
      .legal     (dec_legal),
      .is_load   (dec_load),
      .is_branch (dec_branch),
      .writes_rd (dec_wr)
   );

   assign dec_in = '{legal: dec_legal, is_load: dec_load,
                     is_branch: dec_branch, writes_rd: dec_wr};

   always_comb begin
      flags_n = flags;
      if (state == ST_FETCH && instr_valid) begin
         flags_n = dec_in;
      end

      state_n = state;
      case (state)
         ST_RESET:  state_n = ST_FETCH;
         ST_FETCH:  if (instr_valid) state_n = ST_DECODE;
         ST_DECODE: state_n = flags.legal ? ST_EXEC : ST_FETCH;
         ST_EXEC:   state_n = flags.is_load ? ST_MEM : ST_WB;
         ST_MEM:    if (mem_ack) state_n = ST_WB;
         ST_WB:     state_n = ST_FETCH;
         default:   state_n = ST_RESET;
      endcase

      // pc_offset is sampled only in WB; the immediate unit registers it in EXEC.
      pc_n = pc;
      if (state == ST_WB) begin
         pc_n = (flags.is_branch && branch_taken) ? pc + pc_offset : pc + PC_STEP;
      end else if (state == ST_DECODE && !flags.legal) begin
         pc_n = pc + PC_STEP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RESET;
         flags     <= '0;
         pc        <= RESET_PC;
         retired   <= 32'd0;
         opcode    <= 7'd0;
         en        <= EN_IDLE;
         instr_req <= 1'b0;
         mem_req   <= 1'b0;
         wb_en     <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state <= state_n;
         flags <= flags_n;
         pc    <= pc_n;

         if (state == ST_FETCH && instr_valid) begin
            opcode <= instr[6:0];
         end
         if (state == ST_WB) begin
            retired <= retired + 32'd1;
         end

         // Moore outputs registered from the next state so they align with it.
         en        <= phase_en(state_n);
         instr_req <= (state_n == ST_FETCH);
         mem_req   <= (state_n == ST_MEM);
         wb_en     <= (state_n == ST_WB) && flags_n.writes_rd;
         illegal   <= (state_n == ST_DECODE) && !flags_n.legal;
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus randomized back-to-back
// instructions, checked against a phase-list reference model.
module tb_instr_sequencer;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] RESET_PC = '0;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ALU = 7'b0110011;

   logic            clk;
   logic            rst;
   logic            instr_req;
   logic            instr_valid;
   logic [31:0]     instr;
   logic [6:0]      opcode;
   logic [3:0]      en;
   logic            mem_req;
   logic            mem_ack;
   logic            branch_taken;
   logic [PC_W-1:0] pc_offset;
   logic [PC_W-1:0] pc;
   logic            wb_en;
   logic            illegal;
   logic [31:0]     retired;

   int checks = 0;
   int errors = 0;

   // Per-cycle record: {en[3:0], instr_req, mem_req, wb_en, illegal}
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   logic [PC_W-1:0] m_pc;
   logic [31:0]     m_ret;
   logic [6:0]      m_opc;

   instr_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_req    (instr_req),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .opcode       (opcode),
      .en           (en),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .branch_taken (branch_taken),
      .pc_offset    (pc_offset),
      .pc           (pc),
      .wb_en        (wb_en),
      .illegal      (illegal),
      .retired      (retired)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic bit legal_op(input logic [6:0] o);
      return (o == OP_LUI) || (o == OP_BR) || (o == OP_LD) || (o == OP_ALU);
   endfunction

   function automatic logic [7:0] rec(input logic [3:0] e, input logic ir,
                                      input logic mr, input logic wb, input logic il);
      return {e, ir, mr, wb, il};
   endfunction

   task automatic build_exp(input logic [31:0] word, input int fwait, input int mwait);
      logic [6:0] o;
      o = word[6:0];
      exp_q.delete();
      repeat (fwait + 1) exp_q.push_back(rec(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0));
      if (!legal_op(o)) begin
         exp_q.push_back(rec(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1));
      end else begin
         exp_q.push_back(rec(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(rec(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0));
         if (o == OP_LD) repeat (mwait + 1) exp_q.push_back(rec(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0));
         exp_q.push_back(rec(4'b0000, 1'b0, 1'b0, (o != OP_BR), 1'b0));
      end
   endtask

   task automatic model_commit(input logic [31:0] word, input logic taken, input logic [PC_W-1:0] off);
      if (!legal_op(word[6:0])) begin
         m_pc = m_pc + 4;
      end else begin
         if (word[6:0] == OP_BR && taken) m_pc = m_pc + off;
         else m_pc = m_pc + 4;
         m_ret = m_ret + 1;
      end
      m_opc = word[6:0];
   endtask

   // ---------------- driver ----------------
   // Starts just after a rising edge with the DUT in its first FETCH cycle and walks
   // the expected phase list, sampling outputs at each falling edge.
   task automatic run_instr(input logic [31:0] word, input int fwait, input int mwait,
                            input logic taken, input logic [PC_W-1:0] off, input int abort_at);
      int fcnt;
      int mcnt;
      logic [7:0] e;
      fcnt = 0;
      mcnt = 0;
      obs_q.delete();
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         obs_q.push_back({en, instr_req, mem_req, wb_en, illegal});
         if (i == abort_at) return;
         e = exp_q[i];
         if (e[3]) begin
            instr_valid = (fcnt == fwait);
            instr       = (fcnt == fwait) ? word : $urandom;
            fcnt++;
         end else begin
            instr_valid = 1'($urandom_range(0, 1));
            instr       = $urandom;
         end
         if (e[2]) begin
            mem_ack = (mcnt == mwait);
            mcnt++;
         end else begin
            mem_ack = 1'($urandom_range(0, 1));
         end
         if (e[7:4] == 4'b0000) begin
            branch_taken = taken;
            pc_offset    = off;
         end else begin
            branch_taken = 1'($urandom_range(0, 1));
            pc_offset    = $urandom;
         end
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      mem_ack     = 1'b0;
   endtask

   task automatic do_reset;
      rst         = 1'b1;
      instr_valid = 1'b0;
      mem_ack     = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      m_pc  = RESET_PC;
      m_ret = 32'd0;
      m_opc = 7'd0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; instr = '0;
      branch_taken = 1'b0; pc_offset = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({en, instr_req, mem_req, wb_en, illegal, pc, retired, opcode} !==
          {4'b0000, 4'b0000, RESET_PC, 32'd0, 7'd0}) begin
         errors++;
         $display("FAIL reset_values: got en=%b req=%b mreq=%b wb=%b ill=%b pc=%h ret=%h opc=%h, expected all zero",
                  en, instr_req, mem_req, wb_en, illegal, pc, retired, opcode);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({en, instr_req} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_release_state: got en=%b req=%b, expected 0000/0", en, instr_req);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({en, instr_req} !== 5'b10001) begin
         errors++;
         $display("FAIL reset_first_fetch: got en=%b req=%b, expected 1000/1", en, instr_req);
      end
      m_pc = RESET_PC; m_ret = 32'd0; m_opc = 7'd0;

      // Load that is aborted by reset during its second MEM cycle.
      build_exp(32'h00002083, 0, 20);
      run_instr(32'h00002083, 0, 20, 1'b0, '0, 4);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL abort_trace[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
         end
      end
      #2 rst = 1'b1;
      mem_ack = 1'b1;
      #1;
      checks++;
      if ({en, instr_req, mem_req, wb_en, illegal, pc, retired, opcode} !==
          {4'b0000, 4'b0000, RESET_PC, 32'd0, 7'd0}) begin
         errors++;
         $display("FAIL midreset_values: got en=%b req=%b mreq=%b wb=%b ill=%b pc=%h ret=%h opc=%h, expected all zero",
                  en, instr_req, mem_req, wb_en, illegal, pc, retired, opcode);
      end
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b0; instr_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({en, instr_req, mem_req, pc} !== {4'b1000, 1'b1, 1'b0, RESET_PC}) begin
         errors++;
         $display("FAIL midreset_restart: got en=%b req=%b mreq=%b pc=%h, expected 1000/1/0/%h",
                  en, instr_req, mem_req, pc, RESET_PC);
      end
      m_pc = RESET_PC; m_ret = 32'd0; m_opc = 7'd0;
   endtask

   task automatic test_lui;
      do_reset();
      build_exp(32'h000120B7, 0, 0);
      run_instr(32'h000120B7, 0, 0, 1'b0, '0, -1);
      model_commit(32'h000120B7, 1'b0, '0);
      foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL lui_trace[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({obs_q[0][7:4], obs_q[1][7:4], obs_q[2][7:4], obs_q[3][7:4], obs_q[3][1]} !== 17'b1000_0001_0010_0000_1) begin
         errors++;
         $display("FAIL lui_en_seq: got %b %b %b %b wb=%b, expected 1000 0001 0010 0000 wb=1",
                  obs_q[0][7:4], obs_q[1][7:4], obs_q[2][7:4], obs_q[3][7:4], obs_q[3][1]);
      end
      checks++;
      if ({pc, retired, opcode} !== {32'h4, 32'd1, 7'h37}) begin
         errors++;
         $display("FAIL lui_state: got pc=%h ret=%0d opc=%h, expected pc=4 ret=1 opc=37", pc, retired, opcode);
      end
   endtask

   task automatic test_load;
      int nmem;
      do_reset();
      build_exp(32'h00002083, 0, 2);
      run_instr(32'h00002083, 0, 2, 1'b0, '0, -1);
      model_commit(32'h00002083, 1'b0, '0);
      foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL load_trace[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
         end
      end
      nmem = 0;
      foreach (obs_q[i]) if (obs_q[i][2] && obs_q[i][7:4] == 4'b0100) nmem++;
      checks++;
      if (nmem != 3 || obs_q.size() != 7 || obs_q[6][1] !== 1'b1) begin
         errors++;
         $display("FAIL load_mem_cycles: got mem=%0d len=%0d wb7=%b, expected mem=3 len=7 wb7=1",
                  nmem, obs_q.size(), obs_q[obs_q.size()-1][1]);
      end
      checks++;
      if (pc !== 32'h4) begin
         errors++;
         $display("FAIL load_pc: got %h expected 00000004", pc);
      end
   endtask

   task automatic test_branch;
      // Taken branch from pc=4 (left there by the load test).
      build_exp(32'h00000063, 0, 0);
      run_instr(32'h00000063, 0, 0, 1'b1, 32'h10, -1);
      model_commit(32'h00000063, 1'b1, 32'h10);
      foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL br_taken_trace[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (pc !== 32'h14 || obs_q[3][1] !== 1'b0) begin
         errors++;
         $display("FAIL br_taken_pc: got pc=%h wb=%b, expected pc=00000014 wb=0", pc, obs_q[3][1]);
      end
      // Not-taken branch, again from pc=4.
      do_reset();
      build_exp(32'h000120B7, 1, 0);
      run_instr(32'h000120B7, 1, 0, 1'b0, '0, -1);
      model_commit(32'h000120B7, 1'b0, '0);
      build_exp(32'h00000063, 0, 0);
      run_instr(32'h00000063, 0, 0, 1'b0, 32'h10, -1);
      model_commit(32'h00000063, 1'b0, 32'h10);
      foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL br_not_taken_trace[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (pc !== 32'h8 || retired !== 32'd2) begin
         errors++;
         $display("FAIL br_not_taken_pc: got pc=%h ret=%0d, expected pc=00000008 ret=2", pc, retired);
      end
   endtask

   task automatic test_illegal;
      logic [PC_W-1:0] p0;
      logic [31:0]     r0;
      bit              saw_exec;
      p0 = m_pc;
      r0 = m_ret;
      build_exp(32'h0000007F, 1, 0);
      run_instr(32'h0000007F, 1, 0, 1'b0, '0, -1);
      model_commit(32'h0000007F, 1'b0, '0);
      foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL illegal_trace[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
         end
      end
      saw_exec = 1'b0;
      foreach (obs_q[i]) if (obs_q[i][7:4] == 4'b0010) saw_exec = 1'b1;
      checks++;
      if (saw_exec || obs_q[2][0] !== 1'b1 || obs_q[2][7:4] !== 4'b0001) begin
         errors++;
         $display("FAIL illegal_pulse: got exec_seen=%0d decode_rec=%b, expected exec_seen=0 decode_rec=00010001",
                  saw_exec, obs_q[2]);
      end
      checks++;
      if (pc !== p0 + 32'd4 || retired !== r0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_state: got pc=%h ret=%0d ill=%b, expected pc=%h ret=%0d ill=0",
                  pc, retired, illegal, p0 + 32'd4, r0);
      end
   endtask

   task automatic test_wrap;
      logic [PC_W-1:0] off;
      off = 32'hFFFF_FFFC - m_pc;
      build_exp(32'h00000063, 0, 0);
      run_instr(32'h00000063, 0, 0, 1'b1, off, -1);
      model_commit(32'h00000063, 1'b1, off);
      checks++;
      if (pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_setup_pc: got %h expected fffffffc", pc);
      end
      build_exp(32'h000120B7, 0, 0);
      run_instr(32'h000120B7, 0, 0, 1'b0, '0, -1);
      model_commit(32'h000120B7, 1'b0, '0);
      checks++;
      if (pc !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pc: got %h expected 00000000", pc);
      end
      force dut.retired = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.retired;
      m_ret = 32'hFFFF_FFFF;
      build_exp(32'h002081B3, 0, 0);
      run_instr(32'h002081B3, 0, 0, 1'b0, '0, -1);
      model_commit(32'h002081B3, 1'b0, '0);
      checks++;
      if (retired !== 32'd0 || pc !== 32'h4) begin
         errors++;
         $display("FAIL wrap_retired: got ret=%h pc=%h, expected ret=00000000 pc=00000004", retired, pc);
      end
   endtask

   task automatic test_back_to_back;
      logic [6:0]      opc;
      logic [31:0]     word;
      logic [PC_W-1:0] off;
      logic            taken;
      int              fwait;
      int              mwait;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 4))
            0: opc = OP_LUI;
            1: opc = OP_BR;
            2: opc = OP_LD;
            3: opc = OP_ALU;
            default: begin
               do opc = 7'($urandom); while (legal_op(opc));
            end
         endcase
         word  = {25'($urandom), opc};
         fwait = $urandom_range(0, 3);
         mwait = $urandom_range(0, 3);
         taken = 1'($urandom_range(0, 1));
         off   = $urandom;
         build_exp(word, fwait, mwait);
         run_instr(word, fwait, mwait, taken, off, -1);
         model_commit(word, taken, off);
         foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rand_trace n=%0d[%0d] word=%h: got %b expected %b", n, i, word, obs_q[i], exp_q[i]);
            end
         end
         checks++;
         if ({pc, retired, opcode} !== {m_pc, m_ret, m_opc}) begin
            errors++;
            $display("FAIL rand_state n=%0d word=%h: got pc=%h ret=%0d opc=%h, expected pc=%h ret=%0d opc=%h",
                     n, word, pc, retired, opcode, m_pc, m_ret, m_opc);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_lui();
      test_load();
      test_branch();
      test_illegal();
      test_wrap();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
